sort_gather4: RTL and testbench

SORT_GATHER4 -- requirements
Module: sort_gather4

---
 rtl/sort_gather4_if.sv | 35 +++
 rtl/sort_gather4.sv | 124 ++++++++++++
 tb/tb_sort_gather4.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_gather4_if.sv
// rtl/sort_gather4_if.sv - sample/group handshake bundle for sort_gather4
// The flush input exists only when SORT_GATHER_FLUSH_EN is defined.
interface sort_gather4_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_a;
  logic [3:0] out_b;
  logic [3:0] out_c;
  logic [3:0] out_d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] grp_cnt;
`ifdef SORT_GATHER_FLUSH_EN
  logic       flush;

  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_a, out_b, out_c, out_d, out_valid, grp_cnt
  );
  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_a, out_b, out_c, out_d, out_valid, grp_cnt
  );
`else
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_a, out_b, out_c, out_d, out_valid, grp_cnt
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_a, out_b, out_c, out_d, out_valid, grp_cnt
  );
`endif
endinterface

// File: rtl/sort_gather4.sv
// rtl/sort_gather4.sv - gathers 4 serial samples into a group for a 4-input sorter
// Optional partial-group flush with PAD_VALUE padding: define SORT_GATHER_FLUSH_EN.
module sort_gather4 #(
  parameter logic [3:0] PAD_VALUE = 4'hF
) (
  input  logic           clk,
  input  logic           rst_n,
  sort_gather4_if.slave  bus
);

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_STALL} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_slot;
  logic [3:0] r_fill [4];
  logic [3:0] r_out  [4];
  logic [7:0] r_grp_cnt;

  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_in_hs;
  logic       w_out_hs;
  logic       w_complete;
  logic       w_load_grp;
  logic       w_load_fill;
  logic [3:0] w_grp [4];

  // STALL means the fill buffer holds a whole parked group
  assign w_in_ready  = (r_state != S_STALL);
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_hs     = bus.in_valid && w_in_ready;
  assign w_out_hs    = w_out_valid && bus.out_ready;

`ifdef SORT_GATHER_FLUSH_EN
  logic w_flush;
  assign w_flush    = bus.flush && (r_slot != 2'd0) && (r_state != S_STALL);
  assign w_complete = (w_in_hs && (r_slot == 2'd3)) || w_flush;

  // Stored slots first, then this cycle's sample, then padding
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_grp[i] = PAD_VALUE;
      if (2'(i) < r_slot)
        w_grp[i] = r_fill[i];
      else if ((2'(i) == r_slot) && w_in_hs)
        w_grp[i] = bus.in_data;
    end
  end
`else
  assign w_complete = w_in_hs && (r_slot == 2'd3);

  always_comb begin
    w_grp[0] = r_fill[0];
    w_grp[1] = r_fill[1];
    w_grp[2] = r_fill[2];
    w_grp[3] = bus.in_data;
  end
`endif

  assign w_load_grp  = w_complete && ((r_state == S_EMPTY) || w_out_hs);
  assign w_load_fill = (r_state == S_STALL) && w_out_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_EMPTY;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_complete) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_complete && !w_out_hs)
          w_state_nxt = S_STALL;
        else if (!w_complete && w_out_hs)
          w_state_nxt = S_EMPTY;
      end
      S_STALL: if (w_out_hs) w_state_nxt = S_HOLD;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot    <= 2'd0;
      r_grp_cnt <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        r_fill[i] <= PAD_VALUE;
        r_out[i]  <= 4'd0;
      end
    end else begin
      if (w_out_hs)
        r_grp_cnt <= r_grp_cnt + 8'd1;

      if (w_complete)
        r_slot <= 2'd0;
      else if (w_in_hs)
        r_slot <= r_slot + 2'd1;

      if (w_load_grp)
        r_out <= w_grp;
      else if (w_load_fill)
        r_out <= r_fill;

      // A group that cannot reach the output yet is parked whole in the fill buffer
      if (w_complete && !w_load_grp)
        r_fill <= w_grp;
      else if (w_in_hs && !w_complete)
        r_fill[r_slot] <= bus.in_data;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_a     = r_out[0];
  assign bus.out_b     = r_out[1];
  assign bus.out_c     = r_out[2];
  assign bus.out_d     = r_out[3];
  assign bus.grp_cnt   = r_grp_cnt;

endmodule

// File: tb/tb_sort_gather4.sv
// tb/tb_sort_gather4.sv - self-checking bench for sort_gather4 against a group-queue model
module tb_sort_gather4;

`ifdef SORT_GATHER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif
  localparam logic [3:0] PAD = 4'hF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Model: samples of the group being gathered, and completed groups not yet handed off
  logic [3:0]  m_partial [$];
  logic [15:0] m_pend [$];
  int          m_cnt = 0;

  sort_gather4_if bus ();

  sort_gather4 #(.PAD_VALUE(PAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic v, input logic [3:0] d, input logic r, input logic f);
    bit can_take = (m_pend.size() < 2);
    bit in_hs    = v && can_take;
    bit out_hs   = (m_pend.size() > 0) && r;
    bit fl       = FLUSH_EN && f && (m_partial.size() > 0) && can_take;
    if (out_hs) begin
      m_pend.delete(0);
      m_cnt = (m_cnt + 1) % 256;
    end
    if (in_hs) m_partial.push_back(d);
    if (m_partial.size() == 4 || fl) begin
      while (m_partial.size() < 4) m_partial.push_back(PAD);
      m_pend.push_back({m_partial[0], m_partial[1], m_partial[2], m_partial[3]});
      m_partial.delete();
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic r, input logic f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
`ifdef SORT_GATHER_FLUSH_EN
    bus.flush     = f;
`endif
    @(posedge clk);
    model_step(v, d, r, f);
    @(negedge clk);
  endtask

  task automatic model_clear();
    m_partial.delete();
    m_pend.delete();
    m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
`ifdef SORT_GATHER_FLUSH_EN
    bus.flush = 1'b0;
`endif
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  function automatic logic [15:0] outs();
    return {bus.out_a, bus.out_b, bus.out_c, bus.out_d};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (outs() !== 16'h0000) begin failures++; $display("FAIL reset_out: got %h expected 0000", outs()); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.grp_cnt !== 8'd0) begin failures++; $display("FAIL reset_grp_cnt: got %0d expected 0", bus.grp_cnt); end
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 4'd3, 1, 0);
    drive(1, 4'd9, 1, 0);
    drive(1, 4'd1, 1, 0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", bus.out_valid); end
    drive(1, 4'd7, 1, 0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", bus.out_valid); end
    checks++; if (outs() !== 16'h3917) begin failures++; $display("FAIL basic_group: got %h expected 3917", outs()); end
    drive(0, 4'd0, 1, 0);
    checks++; if (bus.grp_cnt !== 8'd1) begin failures++; $display("FAIL basic_grp_cnt: got %0d expected 1", bus.grp_cnt); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drop: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 4'(i), 0, 0);
      if (i >= 4) begin
        checks++; if (outs() !== 16'h1234) begin failures++; $display("FAIL bp_hold_%0d: got %h expected 1234", i, outs()); end
      end
    end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_stall: got %b expected 0", bus.in_ready); end
    drive(0, 4'd0, 1, 0);
    checks++; if (outs() !== 16'h5678) begin failures++; $display("FAIL bp_second: got %h expected 5678", outs()); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.grp_cnt !== 8'd1) begin failures++; $display("FAIL bp_grp_cnt: got %0d expected 1", bus.grp_cnt); end
    drive(0, 4'd0, 1, 0);
    checks++; if (bus.grp_cnt !== 8'd2) begin failures++; $display("FAIL bp_grp_cnt2: got %0d expected 2", bus.grp_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 7; i++) drive(1, 4'(i), 0, 0);
    drive(1, 4'd8, 1, 0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b expected 1", bus.out_valid); end
    checks++; if (outs() !== 16'h5678) begin failures++; $display("FAIL b2b_group: got %h expected 5678", outs()); end
    checks++; if (bus.grp_cnt !== 8'd1) begin failures++; $display("FAIL b2b_grp_cnt: got %0d expected 1", bus.grp_cnt); end
    drive(0, 4'd0, 1, 0);
    checks++; if (bus.grp_cnt !== 8'd2) begin failures++; $display("FAIL b2b_grp_cnt2: got %0d expected 2", bus.grp_cnt); end
  endtask

`ifdef SORT_GATHER_FLUSH_EN
  task automatic test_flush();
    do_reset();
    drive(1, 4'd5, 1, 0);
    drive(1, 4'd2, 1, 0);
    drive(0, 4'd0, 1, 1);
    checks++; if (outs() !== 16'h52FF) begin failures++; $display("FAIL flush_pad: got %h expected 52ff", outs()); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_valid: got %b expected 1", bus.out_valid); end
    drive(0, 4'd0, 1, 0);
    drive(0, 4'd0, 1, 1);
    drive(0, 4'd0, 1, 0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty: got %b expected 0", bus.out_valid); end
    checks++; if (bus.grp_cnt !== 8'd1) begin failures++; $display("FAIL flush_empty_cnt: got %0d expected 1", bus.grp_cnt); end
    drive(1, 4'd5, 0, 0);
    drive(1, 4'd2, 0, 0);
    drive(1, 4'd6, 0, 1);
    checks++; if (outs() !== 16'h526F) begin failures++; $display("FAIL flush_with_hs: got %h expected 526f", outs()); end
  endtask
`endif

  task automatic test_mid_reset();
    do_reset();
    for (int i = 1; i <= 6; i++) drive(1, 4'(i), 0, 0);
    rst_n = 1'b0;
    #1;
    checks++; if (outs() !== 16'h0000) begin failures++; $display("FAIL midrst_out: got %h expected 0000", outs()); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", bus.out_valid); end
    #1;
    rst_n = 1'b1;
    model_clear();
    drive(1, 4'd4, 0, 0);
    drive(1, 4'd4, 0, 0);
    drive(1, 4'd0, 0, 0);
    drive(1, 4'd2, 0, 0);
    checks++; if (outs() !== 16'h4402) begin failures++; $display("FAIL midrst_group: got %h expected 4402", outs()); end
    for (int i = 0; i < 4; i++) drive(1, 4'(i + 9), 0, 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_clear();
    drive(0, 4'd0, 1, 0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stallrst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.grp_cnt !== 8'd0) begin failures++; $display("FAIL stallrst_cnt: got %0d expected 0", bus.grp_cnt); end
  endtask

  task automatic test_random();
    logic v, r, f;
    logic [3:0] d;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 4'($urandom);
      r = ((i % 64) < 20) ? 1'b0 : ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 7) == 0);
      drive(v, d, r, f);
      checks++;
      if (bus.out_valid !== (m_pend.size() > 0)) begin
        failures++; $display("FAIL rand_valid @%0d: got %b expected %b", i, bus.out_valid, m_pend.size() > 0);
      end
      checks++;
      if (bus.in_ready !== (m_pend.size() < 2)) begin
        failures++; $display("FAIL rand_in_ready @%0d: got %b expected %b", i, bus.in_ready, m_pend.size() < 2);
      end
      checks++;
      if (bus.grp_cnt !== 8'(m_cnt)) begin
        failures++; $display("FAIL rand_grp_cnt @%0d: got %0d expected %0d", i, bus.grp_cnt, m_cnt);
      end
      if (m_pend.size() > 0) begin
        checks++;
        if (outs() !== m_pend[0]) begin
          failures++; $display("FAIL rand_group @%0d: got %h expected %h", i, outs(), m_pend[0]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      drive(1, 4'($urandom), 1, 0);
      checks++;
      if (bus.grp_cnt !== 8'(m_cnt)) begin
        failures++; $display("FAIL wrap_cnt @%0d: got %0d expected %0d", i, bus.grp_cnt, m_cnt);
      end
    end
    checks++; if (bus.grp_cnt !== 8'd255) begin failures++; $display("FAIL wrap_255: got %0d expected 255", bus.grp_cnt); end
    drive(0, 4'd0, 1, 0);
    checks++; if (bus.grp_cnt !== 8'd0) begin failures++; $display("FAIL wrap_zero: got %0d expected 0", bus.grp_cnt); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b0;
`ifdef SORT_GATHER_FLUSH_EN
    bus.flush     = 1'b0;
`endif
    #12;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
`ifdef SORT_GATHER_FLUSH_EN
    test_flush();
`endif
    test_mid_reset();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
